// File: rtl/power_noise_pkg.sv
// Shared types and helpers for the power_noise_sched sequencer: FSM state
// encoding, the per-lane seed stride, the shadow configuration struct and
// the lane-picking functions used while ramping up and down.
package power_noise_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RAMP_UP,
        BURST,
        GAP,
        RAMP_DOWN
    } state_t;

    localparam logic [31:0] SEED_STRIDE = 32'h9E3779B9;

    // Widest supported configuration; instances use the low bits only.
    localparam int MAX_LANES = 16;
    localparam int MAX_CNT_W = 32;

    typedef struct packed {
        logic [MAX_CNT_W-1:0] burst_len;
        logic [MAX_CNT_W-1:0] gap_len;
        logic [MAX_LANES-1:0] mask;
        logic [31:0]          seed;
    } cfg_t;

    // One-hot of the lowest masked lane that is not yet enabled (0 if none).
    function automatic logic [MAX_LANES-1:0] next_set_up(
        input logic [MAX_LANES-1:0] mask,
        input logic [MAX_LANES-1:0] enabled
    );
        logic [MAX_LANES-1:0] cand;
        cand = mask & ~enabled;
        return cand & (~cand + MAX_LANES'(1));
    endfunction

    // One-hot of the highest masked lane that is currently enabled (0 if none).
    function automatic logic [MAX_LANES-1:0] next_set_down(
        input logic [MAX_LANES-1:0] mask,
        input logic [MAX_LANES-1:0] enabled
    );
        logic [MAX_LANES-1:0] cand;
        logic [MAX_LANES-1:0] pick;
        cand = mask & enabled;
        pick = '0;
        for (int i = 0; i < MAX_LANES; i++) begin
            if (cand[i]) begin
                pick    = '0;
                pick[i] = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/power_noise_phase_timer.sv
// Loadable down-counter shared by the stagger, burst and gap phases.
// A loaded value N makes done assert in the Nth cycle after the load,
// so a length of 1 lasts exactly one cycle.
module power_noise_phase_timer
    import power_noise_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] count;

    // Count down from the loaded length and park at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state is written with <= so every flop samples pre-edge values.
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == CNT_W'(1));

endmodule

// File: rtl/power_noise_sched.sv
// Sequencer for a bank of power_noise generators: staggered ramp-up,
// burst/gap duty cycle, staggered ramp-down, per-lane seed generation.
// Optional activity monitor enabled by defining POWER_NOISE_SCHED_ACTMON_EN.
// CNT_W must not exceed 32 and NUM_LANES must lie in 1..16.
module power_noise_sched
    import power_noise_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int STAGGER   = 8,
    parameter int CNT_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [CNT_W-1:0]        cfg_burst_len,
    input  logic [CNT_W-1:0]        cfg_gap_len,
    input  logic [NUM_LANES-1:0]    cfg_lane_mask,
    input  logic [31:0]             cfg_seed,
    input  logic                    start,
    input  logic                    stop,
    output logic [NUM_LANES-1:0]    lane_enable,
    output logic [NUM_LANES*32-1:0] lane_seed,
    output logic                    busy,
    output logic [CNT_W-1:0]        burst_count
`ifdef POWER_NOISE_SCHED_ACTMON_EN
    ,
    input  logic [NUM_LANES-1:0]    lane_activity,
    output logic [31:0]             act_count
`endif
);

    state_t               state, state_d;
    cfg_t                 cfg_q;
    logic [NUM_LANES-1:0] en_d;
    logic [NUM_LANES-1:0] mask_n;
    logic [NUM_LANES-1:0] up_pick, down_pick, down_rest;
    logic                 up_last;
    logic [CNT_W-1:0]     burst_eff, gap_len, stagger_val, tmr_val;
    logic                 tmr_load, tmr_done, bcnt_inc, start_ok;
    logic                 unused_cfg_bits;

    assign mask_n      = cfg_q.mask[NUM_LANES-1:0];
    assign gap_len     = cfg_q.gap_len[CNT_W-1:0];
    assign burst_eff   = (cfg_q.burst_len[CNT_W-1:0] == '0) ? CNT_W'(1)
                                                            : cfg_q.burst_len[CNT_W-1:0];
    assign stagger_val = CNT_W'(STAGGER);
    // Upper bits of the width-generic shadow struct are never read.
    assign unused_cfg_bits = ^cfg_q;

    assign up_pick   = NUM_LANES'(next_set_up(MAX_LANES'(mask_n), MAX_LANES'(lane_enable)));
    assign up_last   = ((mask_n & ~lane_enable & ~up_pick) == '0);
    assign down_pick = NUM_LANES'(next_set_down(MAX_LANES'(mask_n), MAX_LANES'(lane_enable)));
    assign down_rest = lane_enable & ~down_pick;

    assign start_ok  = (state == IDLE) && start && !stop && (mask_n != '0);
    assign cfg_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    power_noise_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // Latch the config word into the shadow registers while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the shadow config is a handful of flops, not a memory, so it takes reset values.
        if (!rst_n) begin
            cfg_q.burst_len <= MAX_CNT_W'(1);
            cfg_q.gap_len   <= '0;
            cfg_q.mask      <= MAX_LANES'({NUM_LANES{1'b1}});
            cfg_q.seed      <= '0;
        end else if (cfg_valid && cfg_ready) begin
            cfg_q.burst_len <= MAX_CNT_W'(cfg_burst_len);
            cfg_q.gap_len   <= MAX_CNT_W'(cfg_gap_len);
            cfg_q.mask      <= MAX_LANES'(cfg_lane_mask);
            cfg_q.seed      <= cfg_seed;
        end
    end

    // Per-lane seeds derive from the shadow base seed with a golden-ratio stride.
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_seed
        assign lane_seed[32*g +: 32] = cfg_q.seed + SEED_STRIDE * 32'(g);
    end

    // State, lane enables and burst counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            lane_enable <= '0;
            burst_count <= '0;
        end else begin
            state       <= state_d;
            lane_enable <= en_d;
            if (start_ok) begin
                burst_count <= '0;
            end else if (bcnt_inc && (burst_count != '1)) begin
                burst_count <= burst_count + 1'b1;
            end
        end
    end

    // Next-state, next lane enables and timer reloads.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
        state_d  = state;
        en_d     = lane_enable;
        tmr_load = 1'b0;
        tmr_val  = stagger_val;
        bcnt_inc = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    en_d     = up_pick;
                    tmr_load = 1'b1;
                    if (up_last) begin
                        state_d = BURST;
                        tmr_val = burst_eff;
                    end else begin
                        state_d = RAMP_UP;
                    end
                end
            end
            RAMP_UP: begin
                if (stop) begin
                    en_d     = down_rest;
                    tmr_load = 1'b1;
                    state_d  = (down_rest == '0) ? IDLE : RAMP_DOWN;
                end else if (tmr_done) begin
                    en_d     = lane_enable | up_pick;
                    tmr_load = 1'b1;
                    if (up_last) begin
                        state_d = BURST;
                        tmr_val = burst_eff;
                    end
                end
            end
            BURST: begin
                if (stop) begin
                    en_d     = down_rest;
                    tmr_load = 1'b1;
                    state_d  = (down_rest == '0) ? IDLE : RAMP_DOWN;
                end else if (tmr_done) begin
                    bcnt_inc = 1'b1;
                    tmr_load = 1'b1;
                    if (gap_len != '0) begin
                        state_d = GAP;
                        en_d    = '0;
                        tmr_val = gap_len;
                    end else begin
                        tmr_val = burst_eff;
                    end
                end
            end
            GAP: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (tmr_done) begin
                    state_d  = BURST;
                    en_d     = mask_n;
                    tmr_load = 1'b1;
                    tmr_val  = burst_eff;
                end
            end
            RAMP_DOWN: begin
                if (tmr_done) begin
                    en_d     = down_rest;
                    tmr_load = 1'b1;
                    if (down_rest == '0) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                en_d    = '0;
            end
        endcase
    end

`ifdef POWER_NOISE_SCHED_ACTMON_EN
    // Count cycles in which any enabled lane reports activity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_count <= '0;
        end else if (start_ok) begin
            act_count <= '0;
        end else if ((|(lane_activity & lane_enable)) && (act_count != '1)) begin
            act_count <= act_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_power_noise_sched.sv
// Self-checking bench for power_noise_sched. Expected lane enables, busy
// and burst counts come from a cycle-indexed schedule model built from
// rise/fall times and burst/gap periods.
module tb_power_noise_sched;

    localparam int NL = 4;
    localparam int S  = 8;
    localparam int CW = 16;
    localparam logic [31:0] STRIDE = 32'h9E3779B9;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            cfg_valid = 1'b0;
    logic            cfg_ready;
    logic [CW-1:0]   cfg_burst_len = '0;
    logic [CW-1:0]   cfg_gap_len = '0;
    logic [NL-1:0]   cfg_lane_mask = '0;
    logic [31:0]     cfg_seed = '0;
    logic            start = 1'b0;
    logic            stop = 1'b0;
    logic [NL-1:0]   lane_enable;
    logic [NL*32-1:0] lane_seed;
    logic            busy;
    logic [CW-1:0]   burst_count;
`ifdef POWER_NOISE_SCHED_ACTMON_EN
    logic [NL-1:0]   lane_activity = '0;
    logic [31:0]     act_count;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    power_noise_sched #(.NUM_LANES(NL), .STAGGER(S), .CNT_W(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_burst_len (cfg_burst_len),
        .cfg_gap_len   (cfg_gap_len),
        .cfg_lane_mask (cfg_lane_mask),
        .cfg_seed      (cfg_seed),
        .start         (start),
        .stop          (stop),
        .lane_enable   (lane_enable),
        .lane_seed     (lane_seed),
        .busy          (busy),
        .burst_count   (burst_count)
`ifdef POWER_NOISE_SCHED_ACTMON_EN
        ,
        .lane_activity (lane_activity),
        .act_count     (act_count)
`endif
    );

    // ---------------- reference schedule model ----------------
    // Cycle k = value seen after the k-th clock edge following the start
    // sample; stop is high during cycle sk.
    function automatic int popc(input int mask);
        int c = 0;
        for (int i = 0; i < NL; i++) if (mask[i]) c++;
        return c;
    endfunction

    function automatic int ramp_end(input int mask);
        return 1 + (popc(mask) - 1) * S;
    endfunction

    function automatic int rise_at(input int mask, input int lane);
        int j = 0;
        for (int i = 0; i < lane; i++) if (mask[i]) j++;
        return 1 + j * S;
    endfunction

    function automatic int run_en(input int mask, input int be, input int g, input int k);
        int r = ramp_end(mask);
        int e = 0;
        bit on;
        for (int l = 0; l < NL; l++) begin
            if (mask[l]) begin
                if (k < r) on = (rise_at(mask, l) <= k);
                else       on = (g == 0) || (((k - r) % (be + g)) < be);
                if (on) e |= (1 << l);
            end
        end
        return e;
    endfunction

    function automatic bit stop_in_gap(input int mask, input int be, input int g, input int sk);
        int r = ramp_end(mask);
        return (sk >= r) && (g != 0) && (((sk - r) % (be + g)) >= be);
    endfunction

    function automatic int exp_en(input int mask, input int be, input int g, input int sk, input int k);
        int e, res, rank;
        if (k <= sk) return run_en(mask, be, g, k);
        if (stop_in_gap(mask, be, g, sk)) return 0;
        e = run_en(mask, be, g, sk);
        res = 0;
        rank = 0;
        for (int l = NL - 1; l >= 0; l--) begin
            if (e[l]) begin
                if (k < sk + 1 + rank * S) res |= (1 << l);
                rank++;
            end
        end
        return res;
    endfunction

    function automatic int idle_at(input int mask, input int be, input int g, input int sk);
        if (stop_in_gap(mask, be, g, sk)) return sk + 1;
        return sk + 1 + (popc(run_en(mask, be, g, sk)) - 1) * S;
    endfunction

    function automatic int exp_bcnt(input int mask, input int be, input int g, input int sk, input int k);
        int lim = (k < sk) ? k : sk;
        int r = ramp_end(mask);
        int n = 0;
        while (r + n * (be + g) + be <= lim) n++;
        return n;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic do_cfg(input int b, input int g, input int m, input logic [31:0] seed);
        @(negedge clk);
        total++;
        if (cfg_ready !== 1'b1) begin
            bad++;
            $display("FAIL cfg_ready_idle got=%b want=1", cfg_ready);
        end
        cfg_valid     = 1'b1;
        cfg_burst_len = CW'(b);
        cfg_gap_len   = CW'(g);
        cfg_lane_mask = NL'(m);
        cfg_seed      = seed;
        @(negedge clk);
        cfg_valid = 1'b0;
        for (int i = 0; i < NL; i++) begin
            total++;
            if (lane_seed[32*i +: 32] !== seed + STRIDE * 32'(i)) begin
                bad++;
                $display("FAIL lane_seed[%0d] got=%h want=%h", i, lane_seed[32*i +: 32],
                         seed + STRIDE * 32'(i));
            end
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy === 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL %s idle_timeout busy=%b want=0", name, busy);
        end
    endtask

    // Start, stop at cycle sk, and compare every cycle until two past idle.
    task automatic run_sched(input string name, input int m, input int b, input int g, input int sk);
        int be = (b == 0) ? 1 : b;
        int idl = idle_at(m, be, g, sk);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= idl + 2; k++) begin
            total++;
            if (lane_enable !== NL'(exp_en(m, be, g, sk, k))) begin
                bad++;
                $display("FAIL %s k=%0d lane_enable got=%b want=%b", name, k, lane_enable,
                         NL'(exp_en(m, be, g, sk, k)));
            end
            total++;
            if (busy !== (k < idl)) begin
                bad++;
                $display("FAIL %s k=%0d busy got=%b want=%b", name, k, busy, (k < idl));
            end
            total++;
            if (burst_count !== CW'(exp_bcnt(m, be, g, sk, k))) begin
                bad++;
                $display("FAIL %s k=%0d burst_count got=%0d want=%0d", name, k, burst_count,
                         exp_bcnt(m, be, g, sk, k));
            end
            stop = (k == sk);
            @(negedge clk);
        end
        stop = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #12;
        total++;
        if (lane_enable !== '0 || busy !== 1'b0 || cfg_ready !== 1'b1 || burst_count !== '0) begin
            bad++;
            $display("FAIL reset_outputs got en=%b busy=%b rdy=%b bc=%0d want 0/0/1/0",
                     lane_enable, busy, cfg_ready, burst_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (lane_seed[64 +: 32] !== 32'h3C6EF372) begin
            bad++;
            $display("FAIL reset_seed2 got=%h want=3c6ef372", lane_seed[64 +: 32]);
        end
        for (int i = 0; i < NL; i++) begin
            total++;
            if (lane_seed[32*i +: 32] !== STRIDE * 32'(i)) begin
                bad++;
                $display("FAIL reset_seed[%0d] got=%h want=%h", i, lane_seed[32*i +: 32],
                         STRIDE * 32'(i));
            end
        end
        total++;
        if (lane_enable !== '0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_quiet got en=%b busy=%b want 0/0", lane_enable, busy);
        end
    endtask

    task automatic test_burst_gap();
        do_cfg(10, 5, 4'b1111, 32'h1000);
        total++;
        if (lane_seed[32 +: 32] !== 32'h9E3789B9) begin
            bad++;
            $display("FAIL seed1 got=%h want=9e3789b9", lane_seed[32 +: 32]);
        end
        run_sched("burst_gap_stop_gap", 15, 10, 5, 50);
        run_sched("burst_gap_stop_burst", 15, 10, 5, 44);
        run_sched("burst_gap_stop_boundary", 15, 10, 5, 34);
    endtask

    task automatic test_ramp_stop();
        do_cfg(10, 0, 4'b0101, 32'hABCD0000);
        run_sched("continuous_stop", 5, 10, 0, 20);
        do_cfg(4, 2, 4'b1111, 32'h0);
        run_sched("stop_in_ramp", 15, 4, 2, 3);
        do_cfg(0, 1, 4'b1000, 32'h7);
        run_sched("single_lane_len0", 8, 0, 1, 9);
    endtask

    task automatic test_random();
        for (int it = 0; it < 12; it++) begin
            int m  = int'($urandom_range(1, 15));
            int b  = int'($urandom_range(0, 6));
            int g  = int'($urandom_range(0, 5));
            int be = (b == 0) ? 1 : b;
            int sk = int'($urandom_range(1, ramp_end(m) + 2 * (be + g) + 2));
            do_cfg(b, g, m, $urandom);
            run_sched($sformatf("rand%0d", it), m, b, g, sk);
        end
    endtask

    task automatic test_idle_corners();
        do_cfg(3, 0, 4'b0011, 32'h1);
        @(negedge clk);
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        total++;
        if (busy !== 1'b0 || lane_enable !== '0) begin
            bad++;
            $display("FAIL start_stop_same got busy=%b en=%b want 0/0", busy, lane_enable);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL stop_alone got busy=%b want 0", busy);
        end
        do_cfg(3, 0, 4'b0000, 32'h2);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (busy !== 1'b0 || lane_enable !== '0) begin
            bad++;
            $display("FAIL zero_mask_start got busy=%b en=%b want 0/0", busy, lane_enable);
        end
    endtask

    task automatic test_cfg_busy();
        do_cfg(50, 0, 4'b1110, 32'hCAFE0000);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cfg_valid     = 1'b1;
        cfg_lane_mask = 4'b0001;
        cfg_seed      = 32'h12345678;
        cfg_burst_len = CW'(2);
        total++;
        if (cfg_ready !== 1'b0) begin
            bad++;
            $display("FAIL cfg_ready_busy got=%b want=0", cfg_ready);
        end
        repeat (2) @(negedge clk);
        cfg_valid = 1'b0;
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_idle("cfg_busy");
        total++;
        if (lane_seed[0 +: 32] !== 32'hCAFE0000) begin
            bad++;
            $display("FAIL cfg_busy_seed got=%h want=cafe0000", lane_seed[0 +: 32]);
        end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (lane_enable !== 4'b0010) begin
            bad++;
            $display("FAIL cfg_busy_mask got=%b want=0010", lane_enable);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_idle("cfg_busy_restart");
    endtask

    task automatic test_async_reset();
        do_cfg(3, 0, 4'b1111, 32'h55);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (34) @(negedge clk);
        total++;
        if (burst_count !== CW'(exp_bcnt(15, 3, 0, 1000, 35)) || lane_enable !== 4'b1111) begin
            bad++;
            $display("FAIL pre_reset got bc=%0d en=%b want bc=%0d en=1111", burst_count,
                     lane_enable, exp_bcnt(15, 3, 0, 1000, 35));
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (lane_enable !== '0 || busy !== 1'b0 || burst_count !== '0 || cfg_ready !== 1'b1) begin
            bad++;
            $display("FAIL async_reset got en=%b busy=%b bc=%0d rdy=%b want 0/0/0/1",
                     lane_enable, busy, burst_count, cfg_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (lane_seed[32 +: 32] !== STRIDE || lane_enable !== '0) begin
            bad++;
            $display("FAIL post_reset got seed1=%h en=%b want %h/0", lane_seed[32 +: 32],
                     lane_enable, STRIDE);
        end
    endtask

`ifdef POWER_NOISE_SCHED_ACTMON_EN
    task automatic test_actmon();
        do_cfg(100, 0, 4'b0001, 32'h0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (act_count !== 32'd0) begin
            bad++;
            $display("FAIL act_clear got=%0d want=0", act_count);
        end
        lane_activity = 4'b0001;
        repeat (7) @(negedge clk);
        lane_activity = 4'b0010;
        repeat (3) @(negedge clk);
        lane_activity = 4'b0000;
        total++;
        if (act_count !== 32'd7) begin
            bad++;
            $display("FAIL act_count got=%0d want=7", act_count);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_idle("actmon");
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_burst_gap();
        test_ramp_stop();
        test_random();
        test_idle_corners();
        test_cfg_busy();
        test_async_reset();
`ifdef POWER_NOISE_SCHED_ACTMON_EN
        test_actmon();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/power_noise_sched.md
Name: power_noise_sched

Overview:
- Sequencer for a bank of NUM_LANES power_noise generators.
- Drives per-lane enable and per-lane seed.
- Enables and disables lanes staggered, STAGGER cycles apart, to limit di/dt steps.
- Once all lanes are on, runs a programmable burst/gap duty cycle until stopped.
- Configured through a valid/ready config port that accepts only while idle. Sits between the test-control register block and the noise generator bank.

Parameters:
- NUM_LANES, 4: number of generator lanes controlled (1..16).
- STAGGER, 8: cycles between successive lane enables/disables during ramps (>=1).
- CNT_W, 16: width of burst/gap lengths and the burst counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- cfg_valid  in  1  config word valid
- cfg_ready  out  1  config accepted; high only in IDLE
- cfg_burst_len  in  CNT_W  burst length in cycles; 0 treated as 1
- cfg_gap_len  in  CNT_W  gap length in cycles; 0 = continuous, no gaps
- cfg_lane_mask  in  NUM_LANES  lanes participating
- cfg_seed  in  32  base seed
- start  in  1  start pulse
- stop  in  1  stop pulse
- lane_enable  out  NUM_LANES  per-lane generator enable, registered
- lane_seed  out  NUM_LANES*32  per-lane seed; lane i in bits [32i+31:32i]
- busy  out  1  state != IDLE
- burst_count  out  CNT_W  completed bursts since last start, saturating

Behaviour:
- Clock clk. Reset rst_n: asynchronous, active-low.
- Reset values:
  - state IDLE; lane_enable 0; busy 0; burst_count 0; cfg_ready 1.
  - Shadow regs: burst_len 1, gap_len 0, mask all-ones, seed 0.
  - lane_seed[i] = i*32'h9E3779B9 (mod 2^32).
- Config handshake:
  - cfg_valid&&cfg_ready latches all cfg_* into shadow regs.
  - On the next cycle, lane_seed[i] = cfg_seed + i*32'h9E3779B9 (mod 2^32).
  - cfg_ready = (state==IDLE); cfg_valid outside IDLE is held off.
- States:
  - IDLE:
    - start with nonzero mask -> RAMP_UP; burst_count cleared.
    - start with mask==0 is ignored.
    - start and stop in the same cycle: stop wins, stay IDLE.
    - stop alone in IDLE is ignored.
  - RAMP_UP:
    - start sampled at cycle T. Lowest masked lane's enable is high at T+1.
    - Each next-higher masked lane goes high STAGGER cycles after the previous one.
    - The cycle the last masked lane goes high is burst cycle 1 -> BURST.
  - BURST:
    - All masked lanes high for burst_len cycles total.
    - At end, burst_count++ (saturate at all-ones).
    - Then -> GAP if gap_len!=0; otherwise stay in BURST with the counter reloaded.
  - GAP:
    - lane_enable=0 for gap_len cycles.
    - Then all masked lanes go high simultaneously (no stagger) -> BURST.
  - RAMP_DOWN:
    - Highest currently-enabled lane goes low the cycle after stop is sampled.
    - Each remaining enabled lane goes low STAGGER cycles after the previous one, in descending order.
    - The update that clears the last lane also sets IDLE; busy falls with it.
- stop sampled in RAMP_UP or BURST -> RAMP_DOWN, starting from the lanes currently enabled.
- stop in GAP -> IDLE next cycle.
- stop has priority over a same-cycle burst/gap boundary.
- start outside IDLE is ignored.
- Async reset at any point forces all lanes off immediately and returns to reset values; no ramp-down.
- All counters are modulo-free down-counters. A length of 1 means exactly one cycle.

Optional Feature:
- Macro POWER_NOISE_SCHED_ACTMON_EN.
- Defined:
  - Adds input lane_activity[NUM_LANES] (each generator's noise_activity) and output act_count[31:0].
  - act_count increments each cycle where the OR over i of (lane_activity[i] & lane_enable[i]) is 1.
  - Saturates at 32'hFFFFFFFF; cleared on accepted start and on reset.
- Undefined: neither port exists; no counter logic.

Decomposition:
- Package power_noise_pkg:
  - state enum (IDLE, RAMP_UP, BURST, GAP, RAMP_DOWN).
  - SEED_STRIDE = 32'h9E3779B9.
  - Packed cfg struct (burst_len, gap_len, mask, seed).
  - Functions next_set_up/next_set_down for finding the next masked lane.
- Sub-module power_noise_phase_timer: loadable CNT_W down-counter with done flag, shared by stagger, burst and gap timing.

Test Plan:
- Reset, then no activity -> lane_enable=0, busy=0, cfg_ready=1, lane_seed[2]=32'h3C6EF372.
- cfg mask=4'b1111, burst=10, gap=5, seed=32'h1000; start at T ->
  - lane_seed[1]=32'h9E3789B9.
  - Lanes 0..3 rise at T+1, T+9, T+17, T+25.
  - All high through T+34, low T+35..T+39, high again at T+40.
  - burst_count=1 at T+35.
- mask=4'b0101, gap=0; start at T; stop at T+20 ->
  - Lane0 rises at T+1, lane2 at T+9; both stay high continuously.
  - Lane2 falls at T+21, lane0 at T+29; busy low from T+29.
- stop at T+3 during ramp (only lane0 on) -> lane0 falls at T+4, IDLE at T+4, lane1 never enabled.
- start+stop same cycle in IDLE -> no change. mask=0 then start -> stays IDLE. cfg_valid while busy -> cfg_ready=0, shadow regs unchanged.
- rst_n low mid-BURST -> lane_enable=0 in the same cycle without waiting for a clock edge; burst_count=0. With ACTMON, lane_activity=4'b0001 for 7 enabled cycles -> act_count=7.
